// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard controller: register offsets,
// STATUS bit positions and receive FSM states.
package kbd_pkg;

    localparam logic DATA_OFF   = 1'b0;
    localparam logic STATUS_OFF = 1'b1;

    localparam int STAT_NE   = 0;
    localparam int STAT_OVF  = 1;
    localparam int STAT_PERR = 2;
    localparam int STAT_FERR = 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous scan-code FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate counter.
module kbd_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_next;
    logic [AW:0] rd_next;
    logic        do_push;
    logic        do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_next = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_next = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            empty  <= (wr_next == rd_next);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/kbd_ctrl.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, decodes
// 11-bit frames, queues scan codes and serves the DATA/STATUS read registers.
module kbd_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        sel,
    input  logic        rd,
    input  logic        reg_addr,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          ps2_clk_s;
    logic          ps2_data_s;
    logic          filt_level;
    logic [FW-1:0] filt_cnt;
    logic          sample_evt;

    rx_state_t     state;
    rx_state_t     state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          parity_ok;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    logic          push_frame;
    logic          set_perr;
    logic          set_ferr;
    logic          set_ovf;
    logic          data_pop;
    logic          stat_clr;
    logic          ovf;
    logic          perr;
    logic          ferr;

    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign ps2_clk_s  = clk_sync[1];
    assign ps2_data_s = data_sync[1];

    // The accepted clock level only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_level <= 1'b1;
            filt_cnt   <= '0;
        end else if (ps2_clk_s == filt_level) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_level <= ps2_clk_s;
            filt_cnt   <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign sample_evt  = filt_level & ~ps2_clk_s & (filt_cnt == FW'(FILTER_LEN - 1));
    assign timeout_hit = (to_cnt == TW'(TIMEOUT));
    assign parity_ok   = ^{shift_reg, parity_bit};

    always_ff @(posedge clk) begin
        if (rst || state == RX_IDLE || sample_evt || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = RX_IDLE;
        end else if (sample_evt) begin
            case (state)
                RX_IDLE:   if (!ps2_data_s) state_next = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP:   state_next = RX_IDLE;
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        push_frame = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        if (state == RX_STOP && sample_evt && !timeout_hit) begin
            push_frame = ps2_data_s & parity_ok;
            set_perr   = ~parity_ok;
            set_ferr   = ~ps2_data_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || timeout_hit) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else if (sample_evt) begin
            case (state)
                RX_IDLE: bit_cnt <= '0;
                RX_DATA: begin
                    shift_reg <= {ps2_data_s, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                RX_PARITY: parity_bit <= ps2_data_s;
                default: ;
            endcase
        end
    end

    assign data_pop = sel & rd & (reg_addr == DATA_OFF) & ~fifo_empty;
    assign stat_clr = sel & rd & (reg_addr == STATUS_OFF);
    assign set_ovf  = push_frame & fifo_full & ~data_pop;

    // A flag being set in the same cycle as a STATUS read keeps the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf  <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovf  <= set_ovf  | (ovf  & ~stat_clr);
            perr <= set_perr | (perr & ~stat_clr);
            ferr <= set_ferr | (ferr & ~stat_clr);
        end
    end

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_frame),
        .pop   (data_pop),
        .din   (shift_reg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign irq = ~fifo_empty;

    always_comb begin
        rd_data = '0;
        if (sel) begin
            if (reg_addr == DATA_OFF) begin
                rd_data[8]   = ~fifo_empty;
                rd_data[7:0] = fifo_empty ? 8'h00 : fifo_dout;
            end else begin
                rd_data[STAT_NE]   = ~fifo_empty;
                rd_data[STAT_OVF]  = ovf;
                rd_data[STAT_PERR] = perr;
                rd_data[STAT_FERR] = ferr;
            end
        end
    end

endmodule

// File: tb/tb_kbd_ctrl.sv
// Self-checking bench for kbd_ctrl: drives PS/2 frames and compares register
// reads against a scan-code queue and flag model.
module tb_kbd_ctrl;

    localparam int FIFO_DEPTH = 16;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 20000;
    localparam int HALF_BIT   = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic        sel;
    logic        rd;
    logic        reg_addr;
    logic [31:0] rd_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    bit         m_ovf;
    bit         m_perr;
    bit         m_ferr;

    always #5 clk = ~clk;

    kbd_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .sel      (sel),
        .rd       (rd),
        .reg_addr (reg_addr),
        .rd_data  (rd_data),
        .irq      (irq)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Records what a complete frame should do to the FIFO and flags.
    task automatic model_frame(input logic [7:0] code, input bit bad_par);
        if (bad_par) m_perr = 1'b1;
        else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(code);
        else m_ovf = 1'b1;
    endtask

    function automatic logic [31:0] next_data();
        if (exp_q.size() == 0) return 32'h0;
        return {23'b0, 1'b1, exp_q.pop_front()};
    endfunction

    function automatic logic [31:0] status_value();
        return {28'b0, m_ferr, m_perr, m_ovf, exp_q.size() != 0};
    endfunction

    function automatic logic model_irq();
        return exp_q.size() != 0;
    endfunction

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nbits);
        logic [10:0] frame;
        logic        par;
        par = ~^code;
        if (bad_par) par = ~par;
        frame = {1'b1, par, code, 1'b0};
        if (nbits == 11) model_frame(code, bad_par);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = frame[i];
            idle(HALF_BIT);
            ps2_clk = 1'b0;
            idle(HALF_BIT);
            ps2_clk = 1'b1;
        end
        idle(HALF_BIT);
        ps2_data = 1'b1;
        idle(2 * HALF_BIT);
    endtask

    task automatic read_reg(input logic addr, output logic [31:0] val);
        @(negedge clk);
        sel      = 1'b1;
        rd       = 1'b1;
        reg_addr = addr;
        #1 val   = rd_data;
        @(negedge clk);
        sel      = 1'b0;
        rd       = 1'b0;
        reg_addr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        end
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rd_data: got %h expected 00000000", rd_data);
        end
        read_reg(1'b1, v);
        checks++;
        if (v !== status_value()) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected %h", v, status_value());
        end
    endtask

    task automatic test_single();
        logic [31:0] v;
        logic [31:0] e;
        send_frame(8'h1C, 1'b0, 11);
        checks++;
        if (irq !== model_irq()) begin
            errors++;
            $display("[TB] FAIL single_irq: got %b expected %b", irq, model_irq());
        end
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL single_unselected: got %h expected 00000000", rd_data);
        end
        read_reg(1'b0, v);
        e = next_data();
        checks++;
        if (v !== e) begin
            errors++;
            $display("[TB] FAIL single_data: got %h expected %h", v, e);
        end
        read_reg(1'b1, v);
        e = status_value();
        checks++;
        if (v !== e) begin
            errors++;
            $display("[TB] FAIL single_status: got %h expected %h", v, e);
        end
        checks++;
        if (irq !== model_irq()) begin
            errors++;
            $display("[TB] FAIL single_irq_clear: got %b expected %b", irq, model_irq());
        end
    endtask

    task automatic test_two_frames();
        logic [31:0] v;
        logic [31:0] e;
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        for (int i = 0; i < 3; i++) begin
            read_reg(1'b0, v);
            e = next_data();
            checks++;
            if (v !== e) begin
                errors++;
                $display("[TB] FAIL two_frames_data%0d: got %h expected %h", i, v, e);
            end
        end
    endtask

    task automatic test_parity();
        logic [31:0] v;
        logic [31:0] e;
        send_frame(8'h1C, 1'b1, 11);
        for (int i = 0; i < 2; i++) begin
            read_reg(1'b1, v);
            e = status_value();
            m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
            checks++;
            if (v !== e) begin
                errors++;
                $display("[TB] FAIL parity_status%0d: got %h expected %h", i, v, e);
            end
        end
        read_reg(1'b0, v);
        e = next_data();
        checks++;
        if (v !== e) begin
            errors++;
            $display("[TB] FAIL parity_data: got %h expected %h", v, e);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        logic [31:0] e;
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) send_frame(8'(i), 1'b0, 11);
        read_reg(1'b1, v);
        e = status_value();
        m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        checks++;
        if (v !== e) begin
            errors++;
            $display("[TB] FAIL overflow_status: got %h expected %h", v, e);
        end
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            read_reg(1'b0, v);
            e = next_data();
            checks++;
            if (v !== e) begin
                errors++;
                $display("[TB] FAIL overflow_data%0d: got %h expected %h", i, v, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        logic [31:0] e;
        send_frame(8'h77, 1'b0, 5);
        idle(TIMEOUT + 10);
        send_frame(8'h29, 1'b0, 11);
        read_reg(1'b1, v);
        e = status_value();
        m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        checks++;
        if (v !== e) begin
            errors++;
            $display("[TB] FAIL timeout_status: got %h expected %h", v, e);
        end
        for (int i = 0; i < 2; i++) begin
            read_reg(1'b0, v);
            e = next_data();
            checks++;
            if (v !== e) begin
                errors++;
                $display("[TB] FAIL timeout_data%0d: got %h expected %h", i, v, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v;
        logic [31:0] e;
        send_frame(8'h11, 1'b0, 11);
        send_frame(8'h22, 1'b0, 11);
        send_frame(8'h33, 1'b0, 11);
        send_frame(8'h44, 1'b0, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        checks++;
        if (irq !== model_irq()) begin
            errors++;
            $display("[TB] FAIL midreset_irq: got %b expected %b", irq, model_irq());
        end
        read_reg(1'b0, v);
        e = next_data();
        checks++;
        if (v !== e) begin
            errors++;
            $display("[TB] FAIL midreset_data: got %h expected %h", v, e);
        end
        idle(4);
        send_frame(8'h5A, 1'b0, 11);
        for (int i = 0; i < 2; i++) begin
            read_reg(1'b0, v);
            e = next_data();
            checks++;
            if (v !== e) begin
                errors++;
                $display("[TB] FAIL midreset_after%0d: got %h expected %h", i, v, e);
            end
        end
        read_reg(1'b1, v);
        e = status_value();
        checks++;
        if (v !== e) begin
            errors++;
            $display("[TB] FAIL midreset_status: got %h expected %h", v, e);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        sel      = 1'b0;
        rd       = 1'b0;
        reg_addr = 1'b0;
        m_ovf    = 1'b0;
        m_perr   = 1'b0;
        m_ferr   = 1'b0;
        test_reset();
        test_single();
        test_two_frames();
        test_parity();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_ctrl.md
# kbd_ctrl

PS/2 keyboard receiver and scan-code FIFO behind the 0xe0000000 keyboard window of the CPU memory interface. Deserialises 11-bit PS/2 frames, checks them, buffers scan codes and serves two memory-mapped read registers on the data-memory path. The interface decodes the 0xe region and drives `sel`; this block supplies the read data.

## Interface
- `FIFO_DEPTH`, 16: scan-code entries; power of two, ≥2.
- `FILTER_LEN`, 8: cycles a synchronised `ps2_clk` level must be stable before it is accepted.
- `TIMEOUT`, 20000: idle clocks mid-frame before the frame is abandoned.

- `clk` in 1: system clock (the interface's `ui_clk`).
- `rst` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `sel` in 1: access targets the keyboard region.
- `rd` in 1: read strobe, one cycle per access.
- `reg_addr` in 1: word offset; 0 = DATA, 1 = STATUS.
- `rd_data` out 32: register read value, combinational.
- `irq` out 1: FIFO non-empty, registered.

## Operation
- Input path: two-flop sync on both lines, then a `ps2_clk` glitch filter. The accepted level changes only after `FILTER_LEN` consecutive equal samples. An accepted 1→0 transition is a sample event; `ps2_data` sync output is sampled on that cycle.
- Receive FSM:
  - IDLE: on a sample event, data=0 → DATA with bit counter 0; data=1 → stay.
  - DATA: shift in LSB first; after the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: data=1 and odd parity over 9 bits → push; parity bad → set PERR, no push; stop=0 → set FERR, no push. Always → IDLE.
- Timeout counter clears on every sample event and counts while not IDLE. On reaching `TIMEOUT`: → IDLE and discard partial byte, no flag.
- FIFO: push on a good frame. Push while full with no pop → byte dropped, OVF set.
- DATA register: `{23'b0, valid, code[7:0]}`. valid = non-empty; code = head entry, or 0 when empty. `sel & rd & reg_addr==0` & non-empty pops the head.
- STATUS register: `{28'b0, FERR, PERR, OVF, nonempty}`. `sel & rd & reg_addr==1` clears FERR/PERR/OVF at the clock edge. The value read is the pre-clear value.
- `rd_data` = 0 when `sel`=0.

## Timing
- Reset: FSM IDLE, FIFO empty, flags 0, filter level 1, timeout 0, `irq`=0, `rd_data`=0.
- Sample event latency: 2 (sync) + `FILTER_LEN` clocks after the raw `ps2_clk` fall.
- Push occurs on the clock edge of the stop-bit sample event. Head is visible on `rd_data` and `irq`=1 the next cycle.
- Pop: `rd_data` is valid in the same cycle as `rd`. The head advances at that edge.
- Simultaneous push+pop:
  - Full: both happen, no OVF.
  - Empty: pop ignored, push lands.
- Simultaneous flag set and STATUS read clear: set wins.
- Pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally. Full = MSBs differ and rest equal.
- Reset mid-frame or with data queued: everything is discarded and the block is back in IDLE next cycle.

## Structure
- Package `kbd_pkg`: DATA/STATUS offsets, STATUS bit indices (NE=0, OVF=1, PERR=2, FERR=3), FSM state enum.
- Sub-module `kbd_fifo`: synchronous FIFO with `push`, `pop`, `din[7:0]`, `dout`, `full`, `empty`.
- Sync, filter, FSM, timeout and register mux stay in `kbd_ctrl`.

## Test plan
- Frame 0x1C, parity 0, stop 1 → `irq`=1. DATA read returns 0x0000011C. STATUS then reads 0x00000000, `irq`=0.
- Frames 0xF0 (parity 1) then 0x1C → DATA reads give 0x000001F0 then 0x0000011C, then 0x00000000 on the third read.
- 0x1C sent with parity 1 → no push. STATUS reads 0x4; the second STATUS read returns 0x0.
- 17 good frames 0x01..0x11, no reads → STATUS 0x3. Sixteen DATA reads return 0x101..0x110; the 17th returns 0x0.
- Five bits sent, line idle for `TIMEOUT`+10 clocks, then good frame 0x29 → only 0x00000129 queued, STATUS NE only.
- `rst` pulsed after 4 data bits with 3 entries queued → `irq`=0, DATA=0. A following frame 0x5A reads 0x0000015A.
